// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, misaligned accesses split into byte beats.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned requests with resp_error instead of splitting.
module load_store_unit #(
    parameter int XLEN       = 64,
    parameter int RD_LATENCY = 1
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [3:0]      req_type,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_error,
    output logic            busy,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [3:0]      mem_loadtype,
    output logic [3:0]      mem_storetype,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [2:0]      dbg_state
);

    // Type codes shared with the core and the data memory.
    localparam logic [3:0] LOAD_BYTE              = 4'h1;
    localparam logic [3:0] LOAD_HALFWORD          = 4'h2;
    localparam logic [3:0] LOAD_WORD              = 4'h3;
    localparam logic [3:0] LOAD_DOUBLEWORD        = 4'h4;
    localparam logic [3:0] LOAD_BYTE_UNSIGNED     = 4'h5;
    localparam logic [3:0] LOAD_HALFWORD_UNSIGNED = 4'h6;
    localparam logic [3:0] STORE_BYTE             = 4'h8;
    localparam logic [3:0] STORE_HALFWORD         = 4'h9;
    localparam logic [3:0] STORE_WORD             = 4'hA;
    localparam logic [3:0] STORE_DOUBLEWORD       = 4'hB;

    localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ACCESS     = 3'd1,
        S_WAIT       = 3'd2,
        S_SPLIT_ACC  = 3'd3,
        S_SPLIT_WAIT = 3'd4,
        S_RESP       = 3'd5
    } lsu_state_t;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle strobe with no back-pressure.

    function automatic logic [2:0] size_m1(input logic [3:0] t);
        case (t)
            LOAD_HALFWORD, LOAD_HALFWORD_UNSIGNED, STORE_HALFWORD: size_m1 = 3'd1;
            LOAD_WORD, STORE_WORD:                                 size_m1 = 3'd3;
            LOAD_DOUBLEWORD, STORE_DOUBLEWORD:                     size_m1 = 3'd7;
            default:                                               size_m1 = 3'd0;
        endcase
    endfunction

    function automatic logic type_ok(input logic is_store, input logic [3:0] t);
        if (is_store)
            type_ok = (t == STORE_BYTE) || (t == STORE_HALFWORD) ||
                      (t == STORE_WORD) || (t == STORE_DOUBLEWORD);
        else
            type_ok = (t == LOAD_BYTE) || (t == LOAD_HALFWORD) || (t == LOAD_WORD) ||
                      (t == LOAD_DOUBLEWORD) || (t == LOAD_BYTE_UNSIGNED) ||
                      (t == LOAD_HALFWORD_UNSIGNED);
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [2:0] nm1,
                                               input logic [3:0] t);
        logic uns;
        uns = (t == LOAD_BYTE_UNSIGNED) || (t == LOAD_HALFWORD_UNSIGNED);
        case (nm1)
            3'd0:    extend = {{(XLEN-8){v[7] & ~uns}}, v[7:0]};
            3'd1:    extend = {{(XLEN-16){v[15] & ~uns}}, v[15:0]};
            3'd3:    extend = {{(XLEN-32){v[31]}}, v[31:0]};
            default: extend = v;
        endcase
    endfunction

    lsu_state_t      r_state;
    lsu_state_t      w_state_next;
    logic            r_rdy_en;
    logic            r_store;
    logic [3:0]      r_type;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_nm1;
    logic [2:0]      r_k;
    logic [1:0]      r_cnt;
    logic [XLEN-1:0] r_asm;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;

    logic            w_accept;
    logic [2:0]      w_req_nm1;
    logic            w_req_ok;
    logic            w_misalign;
    logic            w_last;
    logic            w_lat_done;
    logic [7:0]      w_wbyte;
    logic [XLEN-1:0] w_asm_next;

    assign w_accept   = req_valid && req_ready;
    assign w_req_nm1  = size_m1(req_type);
    assign w_req_ok   = type_ok(req_is_store, req_type);
    assign w_misalign = |(req_addr[2:0] & w_req_nm1);
    assign w_last     = (r_k == r_nm1);
    assign w_lat_done = (r_cnt == LAT_M1);
    assign w_wbyte    = r_wdata[8*r_k +: 8];
    assign dbg_state  = r_state;

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[8*r_k +: 8] = mem_rdata[7:0];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_req_ok)       w_state_next = S_RESP;
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (w_misalign) w_state_next = S_RESP;
`else
                    else if (w_misalign) w_state_next = S_SPLIT_ACC;
`endif
                    else                 w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: w_state_next = r_store ? S_RESP : S_WAIT;
            S_WAIT:   if (w_lat_done) w_state_next = S_RESP;
`ifndef LSU_MISALIGN_TRAP_EN
            S_SPLIT_ACC: begin
                if (!r_store)    w_state_next = S_SPLIT_WAIT;
                else if (w_last) w_state_next = S_RESP;
            end
            S_SPLIT_WAIT: if (w_lat_done) w_state_next = w_last ? S_RESP : S_SPLIT_ACC;
`endif
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_error    = 1'b0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_loadtype  = 4'h0;
        mem_storetype = 4'h0;
        mem_address   = '0;
        mem_wdata     = '0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: req_ready = r_rdy_en;
            S_ACCESS: begin
                mem_address = r_addr;
                mem_wdata   = r_wdata;
                if (r_store) begin
                    mem_write_en  = 1'b1;
                    mem_storetype = r_type;
                end else begin
                    mem_read_en  = 1'b1;
                    mem_loadtype = r_type;
                end
            end
`ifndef LSU_MISALIGN_TRAP_EN
            S_SPLIT_ACC: begin
                mem_address = r_addr + XLEN'(r_k);
                if (r_store) begin
                    mem_write_en  = 1'b1;
                    mem_storetype = STORE_BYTE;
                    mem_wdata     = {{(XLEN-8){1'b0}}, w_wbyte};
                end else begin
                    mem_read_en  = 1'b1;
                    mem_loadtype = LOAD_BYTE_UNSIGNED;
                end
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_error = r_err;
            end
            default: ;
        endcase
    end

    // r_rdy_en keeps req_ready low while reset is held and for the first edge after release.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
            r_store  <= 1'b0;
            r_type   <= 4'h0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_nm1    <= 3'd0;
            r_k      <= 3'd0;
            r_cnt    <= 2'd0;
            r_asm    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_store <= req_is_store;
                        r_type  <= req_type;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_nm1   <= w_req_nm1;
                        r_k     <= 3'd0;
                        r_cnt   <= 2'd0;
                        r_asm   <= '0;
                        r_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        r_err   <= !w_req_ok || w_misalign;
`else
                        r_err   <= !w_req_ok;
`endif
                    end
                end
                S_WAIT: begin
                    if (w_lat_done) begin
                        r_rdata <= mem_rdata;
                        r_cnt   <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
`ifndef LSU_MISALIGN_TRAP_EN
                S_SPLIT_ACC: begin
                    if (r_store && !w_last) r_k <= r_k + 3'd1;
                end
                S_SPLIT_WAIT: begin
                    if (w_lat_done) begin
                        r_cnt <= 2'd0;
                        r_asm <= w_asm_next;
                        if (w_last) r_rdata <= extend(w_asm_next, r_nm1, r_type);
                        else        r_k     <= r_k + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
